// File: rtl/exec_pkg.sv
// exec_pkg: opcodes, flag bit positions and FSM states shared by the execution datapath.
package exec_pkg;
    localparam logic [7:0] OP_AND = 8'h01;
    localparam logic [7:0] OP_OR  = 8'h02;
    localparam logic [7:0] OP_XOR = 8'h03;
    localparam logic [7:0] OP_NOT = 8'h04;
    localparam logic [7:0] OP_ADD = 8'h05;
    localparam logic [7:0] OP_SUB = 8'h06;
    localparam logic [7:0] OP_CMP = 8'h07;
    localparam logic [7:0] OP_MOV = 8'h08;
    localparam logic [7:0] OP_LSH = 8'h09;
    localparam logic [7:0] OP_RSH = 8'h0A;
    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WB} state_t;
endpackage

// File: rtl/exec_alu.sv
// exec_alu: combinational ALU producing result and {C,Z,N,V} for one control word.
module exec_alu
    import exec_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [7:0]  opcode,
    output logic [15:0] result,
    output logic [3:0]  flags,
    output logic        is_shift,
    output logic        is_valid_op
);
    logic [16:0] sum, diff;
    logic c, v;
    assign sum = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign is_shift = opcode == OP_LSH || opcode == OP_RSH;
    always_comb begin
        result = '0;
        c = 1'b0;
        v = 1'b0;
        is_valid_op = 1'b1;
        case (opcode)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_ADD: begin
                result = sum[15:0];
                c = sum[16];
                v = (a[15] == b[15]) && (sum[15] != a[15]);
            end
            OP_SUB, OP_CMP: begin
                result = diff[15:0];
                c = diff[16];
                v = (a[15] != b[15]) && (diff[15] != a[15]);
            end
            OP_MOV: result = b;
            OP_LSH: result = a << b[3:0];
            OP_RSH: result = a >> b[3:0];
            default: is_valid_op = 1'b0;
        endcase
        flags = '0;
        flags[FLAG_C] = c;
        flags[FLAG_Z] = result == '0;
        flags[FLAG_N] = result[15];
        flags[FLAG_V] = v;
    end
endmodule

// File: rtl/exec_datapath.sv
// exec_datapath: register file, operand muxes, ALU and flags executing one control word per handshake.
// EXEC_DATAPATH_R0_ZERO_EN hardwires R0 to zero.
module exec_datapath
    import exec_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SHIFT_STEP = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cw_valid,
    output logic              cw_ready,
    input  logic [DATA_W-1:0] immediate,
    input  logic [DATA_W-1:0] enable,
    input  logic [7:0]        opcode,
    input  logic [4:0]        control1,
    input  logic [4:0]        control2,
    input  logic              imm_control,
    input  logic              buff_en,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_valid,
    output logic [3:0]        flags
);
`ifdef EXEC_DATAPATH_R0_ZERO_EN
    localparam logic [DATA_W-1:0] WR_MASK = {{(DATA_W-1){1'b1}}, 1'b0};
`else
    localparam logic [DATA_W-1:0] WR_MASK = '1;
`endif
    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    state_t state, next_state;
    logic [DATA_W-1:0] regs [16];
    logic [DATA_W-1:0] a, b, alu_result, sh, commit_data, cap_en, commit_en;
    logic [3:0] alu_flags, commit_flags;
    logic [4:0] rem, amt;
    logic cap_buff, cap_left, is_shift, is_valid_op, accept, long_shift, commit, commit_wr;

    assign cw_ready = state == S_IDLE;
    assign accept = cw_valid && cw_ready;
    assign a = control1[4] ? '0 : regs[control1[3:0]];
    assign b = imm_control ? immediate : control2[4] ? '0 : regs[control2[3:0]];
    assign long_shift = is_shift && b[3:0] != 4'd0;
    assign amt = rem < STEP ? rem : STEP;

    exec_alu u_alu (
        .a(a),
        .b(b),
        .opcode(opcode),
        .result(alu_result),
        .flags(alu_flags),
        .is_shift(is_shift),
        .is_valid_op(is_valid_op)
    );

    // Commit comes either from the accepted word directly or from the captured word in WB.
    assign commit = state == S_WB ? cap_buff : accept && is_valid_op && buff_en && !long_shift;
    assign commit_wr = state == S_WB || opcode != OP_CMP;
    assign commit_data = state == S_WB ? sh : alu_result;
    assign commit_en = (state == S_WB ? cap_en : enable) & WR_MASK;
    assign commit_flags = state == S_WB ? {1'b0, sh == '0, sh[DATA_W-1], 1'b0} : alu_flags;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  next_state = accept && long_shift ? S_SHIFT : S_IDLE;
            S_SHIFT: next_state = rem == amt ? S_WB : S_SHIFT;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
            flags <= '0;
            bus_out <= '0;
            bus_valid <= 1'b0;
            sh <= '0;
            rem <= '0;
            cap_en <= '0;
            cap_buff <= 1'b0;
            cap_left <= 1'b0;
        end else begin
            bus_valid <= commit && commit_wr;
            if (accept) begin
                sh <= a;
                rem <= {1'b0, b[3:0]};
                cap_en <= enable;
                cap_buff <= buff_en;
                cap_left <= opcode == OP_LSH;
            end else if (state == S_SHIFT) begin
                sh <= cap_left ? sh << amt : sh >> amt;
                rem <= rem - amt;
            end
            if (commit) begin
                flags <= commit_flags;
                if (commit_wr) begin
                    bus_out <= commit_data;
                    for (int i = 0; i < 16; i++) if (commit_en[i]) regs[i] <= commit_data;
                end
            end
        end
    end
endmodule
